alu4_issuer: RTL
================

# alu4_issuer

Command-side initiator for the 4-bit combinational ALU. Accepts operation commands over a valid/ready interface and buffers them in a small FIFO. Issues each command to the ALU's operand/select bus, captures RESULT and the three flags one cycle later, and returns them over a valid/ready response interface. Sits between a controller or test sequencer and the ALU, turning the ALU into a pipelined, flow-controlled execution unit with optional result chaining.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_sel  in  2  00=ADD, 01=SUB, 10=AND, 11=OR
- cmd_chain  in  1  1 = use last captured result as A; cmd_a ignored
- alu_a, alu_b  out  4  registered operands to ALU
- alu_sel  out  2  registered select to ALU
- alu_result  in  4  ALU RESULT
- alu_carry, alu_zero, alu_overflow  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  4  captured result
- rsp_flags  out  3  {overflow, zero, carry}
- busy  out  1  state ≠ IDLE or FIFO non-empty
- sticky_clr  in  1  clears sticky flags (macro only)
- sticky_flags  out  2  {overflow, carry} accumulated (macro only)

## Operation
- Push on cmd_valid & cmd_ready. Each entry holds {chain, sel, b, a}, 11 bits.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: FIFO non-empty → pop, load alu_a/alu_b/alu_sel, go DRIVE.
- Operand A at load: chain ? last_result : entry.a.
- DRIVE: exactly one cycle. Capture alu_result/flags into rsp_result/rsp_flags and last_result. Go RESP.
- RESP: rsp_valid=1; outputs stable while rsp_ready=0.
  - rsp_ready=1 with FIFO non-empty → pop/load, go DRIVE.
  - rsp_ready=1 with FIFO empty → IDLE.
- alu_* hold their last value outside DRIVE.
- cmd_ready = count < FIFO_DEPTH. Push and pop in the same cycle are both honoured; count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- The block does no arithmetic. The ALU owns all result/flag semantics, including carry as borrow on SUB and overflow forced 0 on AND/OR.
- Reset values: all outputs 0 (cmd_ready 1 once out of reset), FIFO empty, state IDLE, last_result 0.
- Reset mid-operation discards FIFO contents and any pending response. A chain after reset uses A=0.

## Timing
- Command accepted at edge T into an empty FIFO and IDLE:
  - pop/load at edge T+1
  - capture at edge T+2
  - rsp_valid high in cycle T+2
- Back-to-back throughput with rsp_ready held 1: one response per 2 cycles.
- Each response handshake completes at the edge where rsp_valid & rsp_ready.
- A chained command issued directly after RESP sees last_result from the preceding capture. No hazard.
- cmd_ready is combinational from count only, with no path from cmd_valid.

## Configuration
- ALU4_ISSUER_STICKY_FLAGS_EN defined:
  - sticky_flags register, reset 00.
  - ORs in {overflow, carry} at every capture.
  - sticky_clr=1 clears it. If clear and capture coincide, clear wins.
- Undefined: sticky_clr unused; sticky_flags tied 00. The ports remain present.

## Structure
- Shared package alu4_pkg:
  - op encoding constants ALU_ADD/SUB/AND/OR
  - flag bit-index constants
  - FSM state typedef
  - command-entry struct
- One sub-module: alu4_cmd_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count.

## Test plan
- ADD a=7 b=9 → rsp_result 0, flags {ovf 0, zero 1, carry 1}; rsp_valid two cycles after accept.
- SUB a=3 b=5 → result E, carry 1, ovf 0. ADD a=7 b=1 → result 8, ovf 1, carry 0.
- Chain: ADD 2+3, then chained ADD b=4 → results 5 then 9, second ovf 1.
- rsp_ready held 0, FIFO_DEPTH=4:
  - 5 commands accepted, then cmd_ready=0.
  - Release rsp_ready → all 5 responses return in order, one per 2 cycles.
- rst asserted in DRIVE with 3 queued → rsp_valid 0 and busy 0 immediately. After release, a chained ADD b=1 returns 1.
- Macro defined: ADD 7+9 then AND F,F → sticky_flags 01. sticky_clr pulse → 00. Undefined: stays 00.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared types and constants for the alu4_issuer command initiator:
// ALU op encodings, response flag bit positions, FSM states and FIFO entry layout.
package alu4_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Bit positions inside rsp_flags = {overflow, zero, carry}
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_OVF   = 2;

  localparam int CMD_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic       chain;
    logic [1:0] sel;
    logic [3:0] b;
    logic [3:0] a;
  } cmd_entry_t;

endpackage

// File: rtl/alu4_cmd_fifo.sv
// Parameterised synchronous FIFO with show-ahead read data; pushes when full
// and pops when empty are ignored. DEPTH must be a power of two.
module alu4_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s;

  assign full_o  = (count_q == FULL_C);
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu4_issuer.sv
// Flow-controlled issuer for the 4-bit combinational ALU with result chaining.
// Define ALU4_ISSUER_STICKY_FLAGS_EN to accumulate {overflow, carry} in sticky_flags.
module alu4_issuer
  import alu4_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [1:0] cmd_sel,
  input  logic       cmd_chain,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_flags,
  output logic       busy,
  input  logic       sticky_clr,
  output logic [1:0] sticky_flags
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  cmd_entry_t       push_entry_s, head_entry_s;
  logic [CMD_W-1:0] head_raw_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;
  logic             pop_s, capture_s;

  logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0] alu_sel_q, alu_sel_d;
  logic [3:0] rsp_result_q, rsp_result_d, last_result_q, last_result_d;
  logic [2:0] rsp_flags_q, rsp_flags_d;
  logic       rsp_valid_q, rsp_valid_d;

  assign push_entry_s = '{chain: cmd_chain, sel: cmd_sel, b: cmd_b, a: cmd_a};
  assign head_entry_s = head_raw_s;

  alu4_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .wdata_i (push_entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_raw_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign cmd_ready = ~fifo_full_s;
  assign busy      = (state_q != ST_IDLE) | (fifo_count_s != {CW{1'b0}});

  // Sequencer: pop a command, drive the ALU for one cycle, then hold the response
  always_comb begin
    state_d   = state_q;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        capture_s = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand load on pop; result/flag capture at the end of DRIVE
  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    last_result_d = last_result_q;
    if (pop_s) begin
      alu_a_d   = head_entry_s.chain ? last_result_q : head_entry_s.a;
      alu_b_d   = head_entry_s.b;
      alu_sel_d = head_entry_s.sel;
    end else begin
      alu_a_d   = alu_a_q;
    end
    if (capture_s) begin
      rsp_result_d            = alu_result;
      last_result_d           = alu_result;
      rsp_flags_d[FLAG_OVF]   = alu_overflow;
      rsp_flags_d[FLAG_ZERO]  = alu_zero;
      rsp_flags_d[FLAG_CARRY] = alu_carry;
    end else begin
      rsp_result_d = rsp_result_q;
    end
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      alu_a_q       <= 4'h0;
      alu_b_q       <= 4'h0;
      alu_sel_q     <= 2'b00;
      rsp_result_q  <= 4'h0;
      rsp_flags_q   <= 3'b000;
      last_result_q <= 4'h0;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      last_result_q <= last_result_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_valid  = rsp_valid_q;

`ifdef ALU4_ISSUER_STICKY_FLAGS_EN
  logic [1:0] sticky_q, sticky_d;

  // Clear takes priority over a coinciding capture
  always_comb begin
    if (sticky_clr) begin
      sticky_d = 2'b00;
    end else if (capture_s) begin
      sticky_d = sticky_q | {alu_overflow, alu_carry};
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 2'b00;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic sticky_unused_s;
  assign sticky_unused_s = sticky_clr;
  assign sticky_flags    = 2'b00;
`endif

endmodule
